vga_timing_gen: RTL and testbench

Parametrised raster timing generator for the video card. It derives a pixel-rate clock enable from the system clock and steps horizontal and vertical counters through a configurable active/front-porch/sync/back-porch geometry. It produces registered sync, blanking, pixel-coordinate and frame/line strobes for the pixel pipeline. A run/stop handshake starts scanning cleanly at (0,0) and stops only at a frame boundary.

---
 rtl/vga_timing_gen_if.sv | 39 +++
 rtl/vga_timing_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
// Bundles the run request and all raster outputs of the timing generator.
//   i_run         : scan request level, driven by the consumer
//   o_pix_ce      : one-clock pixel enable; other outputs are new on this cycle
//   o_hsync/vsync : syncs at the configured polarity
//   o_drawing     : inside the active area
//   o_vblank      : vertical position at or past the active lines
//   o_x/y_pixel   : active-area coordinates, 0 outside the active area
//   o_line_start  : pixel enable at h=0
//   o_frame_start : pixel enable at (0,0)
//   o_busy        : generator is not idle
// Modports: master = timing generator, slave = pixel pipeline / controller.
interface vga_timing_gen_if #(
  parameter int CW = 12
);
  logic          i_run;
  logic          o_pix_ce;
  logic          o_hsync;
  logic          o_vsync;
  logic          o_drawing;
  logic          o_vblank;
  logic [CW-1:0] o_x_pixel;
  logic [CW-1:0] o_y_pixel;
  logic          o_line_start;
  logic          o_frame_start;
  logic          o_busy;

  modport master (
    input  i_run,
    output o_pix_ce, o_hsync, o_vsync, o_drawing, o_vblank,
    output o_x_pixel, o_y_pixel, o_line_start, o_frame_start, o_busy
  );

  modport slave (
    output i_run,
    input  o_pix_ce, o_hsync, o_vsync, o_drawing, o_vblank,
    input  o_x_pixel, o_y_pixel, o_line_start, o_frame_start, o_busy
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator. Divides i_clk down to a pixel enable, walks the
// horizontal/vertical counters through active, front porch, sync and back
// porch, and presents registered sync, blanking, coordinate and strobe
// outputs. Scanning starts at (0,0) when i_run is seen high while idle, and
// a stop request only takes effect at the end of a frame.
// Ports:
//   i_clk   : system clock
//   i_reset : asynchronous active-high reset
//   vid     : vga_timing_gen_if master modport (i_run in, raster outputs out)
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int CW        = 12,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  vga_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] D_LAST   = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic [DW-1:0] d_q, d_d;

  logic          pix_ce_q, pix_ce_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          drawing_q, drawing_d;
  logic          vblank_q, vblank_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          busy_q, busy_d;

  logic          tick;
  logic          load_pos;
  logic          go_idle;
  logic [CW-1:0] h_nx, v_nx;
  logic          in_active;

  // Next-state and output decode. The position that will be held after this
  // edge (h_nx, v_nx) is decoded here so the registered outputs line up with
  // the counters on the same edge that raises o_pix_ce. Between ticks every
  // level output simply holds; the strobes default low.
  always_comb begin
    state_d       = state_q;
    h_d           = h_q;
    v_d           = v_q;
    d_d           = d_q;
    pix_ce_d      = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    drawing_d     = drawing_q;
    vblank_d      = vblank_q;
    x_d           = x_q;
    y_d           = y_q;
    load_pos      = 1'b0;
    go_idle       = 1'b0;
    h_nx          = h_q;
    v_nx          = v_q;
    in_active     = 1'b0;
    tick          = (d_q == D_LAST);

    case (state_q)
      IDLE: begin
        if (vid.i_run) begin
          state_d  = RUN;
          h_nx     = '0;
          v_nx     = '0;
          d_d      = '0;
          load_pos = 1'b1;
        end else begin
          go_idle = 1'b1;
        end
      end

      RUN, STOPPING: begin
        if (state_q == RUN && !vid.i_run) begin
          state_d = STOPPING;
        end else if (state_q == STOPPING && vid.i_run) begin
          state_d = RUN;
        end

        if (tick) begin
          d_d = '0;
          // A pending stop that is still pending on the last pixel of the
          // frame replaces the wrap with a return to idle.
          if (state_q == STOPPING && !vid.i_run &&
              h_q == H_LAST && v_q == V_LAST) begin
            state_d = IDLE;
            go_idle = 1'b1;
          end else begin
            load_pos = 1'b1;
            if (h_q == H_LAST) begin
              h_nx = '0;
              v_nx = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
              h_nx = h_q + 1'b1;
            end
          end
        end else begin
          d_d = d_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        go_idle = 1'b1;
      end
    endcase

    if (load_pos) begin
      in_active     = (h_nx < H_ACT) && (v_nx < V_ACT);
      h_d           = h_nx;
      v_d           = v_nx;
      pix_ce_d      = 1'b1;
      line_start_d  = (h_nx == '0);
      frame_start_d = (h_nx == '0) && (v_nx == '0);
      drawing_d     = in_active;
      vblank_d      = (v_nx >= V_ACT);
      x_d           = in_active ? h_nx : '0;
      y_d           = in_active ? v_nx : '0;
      hsync_d       = ((h_nx >= HS_START) && (h_nx < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = ((v_nx >= VS_START) && (v_nx < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    end else if (go_idle) begin
      h_d       = '0;
      v_d       = '0;
      d_d       = '0;
      drawing_d = 1'b0;
      vblank_d  = 1'b0;
      x_d       = '0;
      y_d       = '0;
      hsync_d   = ~HSYNC_POL;
      vsync_d   = ~VSYNC_POL;
    end

    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs. Reset drops everything to the
  // idle values immediately, independent of the clock.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= IDLE;
      h_q           <= '0;
      v_q           <= '0;
      d_q           <= '0;
      pix_ce_q      <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      drawing_q     <= 1'b0;
      vblank_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      d_q           <= d_d;
      pix_ce_q      <= pix_ce_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      drawing_q     <= drawing_d;
      vblank_q      <= vblank_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  assign vid.o_pix_ce      = pix_ce_q;
  assign vid.o_hsync       = hsync_q;
  assign vid.o_vsync       = vsync_q;
  assign vid.o_drawing     = drawing_q;
  assign vid.o_vblank      = vblank_q;
  assign vid.o_x_pixel     = x_q;
  assign vid.o_y_pixel     = y_q;
  assign vid.o_line_start  = line_start_q;
  assign vid.o_frame_start = frame_start_q;
  assign vid.o_busy        = busy_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Two generators share clock and reset: dut_a at the default 640x480 geometry
// with a divide-by-2 pixel clock, and dut_b at a tiny 8x6 geometry with a
// pixel every clock and active-high syncs. Flag bundles compared below are
// {pix_ce, hsync, vsync, drawing, vblank, line_start, frame_start, busy}.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(12)) a_if ();
  vga_timing_gen_if #(.CW(12)) b_if ();

  vga_timing_gen dut_a (
    .i_clk   (clk),
    .i_reset (rst),
    .vid     (a_if)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .CW(12),
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_b (
    .i_clk   (clk),
    .i_reset (rst),
    .vid     (b_if)
  );

  typedef struct {
    logic       run;
    logic [7:0] flags;
    int         x;
    int         y;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [7:0] flagsA();
    return {a_if.o_pix_ce, a_if.o_hsync, a_if.o_vsync, a_if.o_drawing,
            a_if.o_vblank, a_if.o_line_start, a_if.o_frame_start, a_if.o_busy};
  endfunction

  function automatic logic [7:0] flagsB();
    return {b_if.o_pix_ce, b_if.o_hsync, b_if.o_vsync, b_if.o_drawing,
            b_if.o_vblank, b_if.o_line_start, b_if.o_frame_start, b_if.o_busy};
  endfunction

  // One comparison: counts it, and reports the failing name with both values.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance n clock edges, leaving time just after the last edge.
  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive the run request of dut_b and advance one edge.
  task automatic applyStimulus(input logic run_b);
    b_if.i_run = run_b;
    stepCycles(1);
  endtask

  initial begin
    int   hs_first, hs_cnt, dr_cnt, pce_cnt, ls_cnt, vs_low, max_x;
    logic bad;
    int   cnt, busy_low;

    // Hand-computed first line and a half of dut_b after run is raised.
    vecs[0]  = '{1'b0, 8'h00, 0, 0};
    vecs[1]  = '{1'b1, 8'h97, 0, 0};
    vecs[2]  = '{1'b1, 8'h91, 1, 0};
    vecs[3]  = '{1'b1, 8'h91, 2, 0};
    vecs[4]  = '{1'b1, 8'h91, 3, 0};
    vecs[5]  = '{1'b1, 8'h81, 0, 0};
    vecs[6]  = '{1'b1, 8'hC1, 0, 0};
    vecs[7]  = '{1'b1, 8'hC1, 0, 0};
    vecs[8]  = '{1'b1, 8'h81, 0, 0};
    vecs[9]  = '{1'b1, 8'h95, 0, 1};
    vecs[10] = '{1'b1, 8'h91, 1, 1};

    a_if.i_run = 1'b0;
    b_if.i_run = 1'b0;
    stepCycles(3);
    rst = 1'b0;

    // dut_a idles for 100 cycles with syncs inactive (high).
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      stepCycles(1);
      if (flagsA() !== 8'h60 || a_if.o_x_pixel !== 12'd0 || a_if.o_y_pixel !== 12'd0)
        bad = 1'b1;
    end
    checkOutput("a_idle_flags", flagsA(), 8'h60);
    checkOutput("a_idle_stable", bad, 1'b0);

    // Start dut_a: (0,0) on the very next edge.
    a_if.i_run = 1'b1;
    stepCycles(1);
    checkOutput("a_start_flags", flagsA(), 8'hF7);
    checkOutput("a_start_x", a_if.o_x_pixel, 0);
    checkOutput("a_start_y", a_if.o_y_pixel, 0);

    // Profile one whole line of dut_a, cycle 0 being the line start.
    hs_first = -1; hs_cnt = 0; dr_cnt = 0; pce_cnt = 0; ls_cnt = 0; vs_low = 0; max_x = 0;
    for (int c = 0; c < 1600; c++) begin
      if (!a_if.o_hsync) begin
        if (hs_first < 0) hs_first = c;
        hs_cnt++;
      end
      if (!a_if.o_vsync) vs_low++;
      if (a_if.o_drawing) dr_cnt++;
      if (a_if.o_pix_ce) pce_cnt++;
      if (a_if.o_line_start) ls_cnt++;
      if (int'(a_if.o_x_pixel) > max_x) max_x = int'(a_if.o_x_pixel);
      stepCycles(1);
    end
    checkOutput("a_hsync_offset", hs_first, 1312);
    checkOutput("a_hsync_len", hs_cnt, 192);
    checkOutput("a_drawing_len", dr_cnt, 1280);
    checkOutput("a_pix_ce_count", pce_cnt, 800);
    checkOutput("a_line_start_count", ls_cnt, 1);
    checkOutput("a_vsync_line0", vs_low, 0);
    checkOutput("a_max_x", max_x, 639);
    checkOutput("a_line1_flags", flagsA(), 8'hF5);
    checkOutput("a_line1_y", a_if.o_y_pixel, 1);
    a_if.i_run = 1'b0;

    // dut_b table: idle, start, first line and the beginning of line 1.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].run);
      checkOutput($sformatf("b_vec%0d_flags", i), flagsB(), vecs[i].flags);
      checkOutput($sformatf("b_vec%0d_x", i), b_if.o_x_pixel, vecs[i].x);
      checkOutput($sformatf("b_vec%0d_y", i), b_if.o_y_pixel, vecs[i].y);
    end

    // Vertical blanking and sync of dut_b (position p = v*8 + h, now p=9).
    stepCycles(15);
    checkOutput("b_vblank_start", flagsB(), 8'h8D);
    checkOutput("b_vblank_y", b_if.o_y_pixel, 0);
    stepCycles(8);
    checkOutput("b_vsync_start", flagsB(), 8'hAD);
    stepCycles(7);
    checkOutput("b_vsync_end_of_line", flagsB(), 8'hA9);
    stepCycles(1);
    checkOutput("b_vsync_off", flagsB(), 8'h8D);
    stepCycles(8);
    checkOutput("b_frame_wrap", flagsB(), 8'h97);

    // Stop request early in the frame: scanning finishes the frame first.
    b_if.i_run = 1'b0;
    stepCycles(47);
    checkOutput("b_stop_last_pixel", flagsB(), 8'h89);
    stepCycles(1);
    checkOutput("b_stop_idle_flags", flagsB(), 8'h00);
    checkOutput("b_stop_idle_xy", {b_if.o_x_pixel, b_if.o_y_pixel}, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      stepCycles(1);
      if (b_if.o_pix_ce) cnt++;
    end
    checkOutput("b_idle_no_pix_ce", cnt, 0);

    // Restart, stop, then cancel the stop mid-frame: no gap into next frame.
    applyStimulus(1'b1);
    checkOutput("b_restart", flagsB(), 8'h97);
    applyStimulus(1'b0);
    checkOutput("b_stopping_busy", flagsB(), 8'h91);
    stepCycles(18);
    b_if.i_run = 1'b1;
    cnt = 0;
    busy_low = 0;
    for (int i = 0; i < 29; i++) begin
      stepCycles(1);
      if (b_if.o_pix_ce) cnt++;
      if (!b_if.o_busy) busy_low++;
    end
    checkOutput("b_resume_pix_ce", cnt, 29);
    checkOutput("b_resume_busy", busy_low, 0);
    checkOutput("b_resume_frame", flagsB(), 8'h97);

    // Asynchronous reset mid-frame at (4,2), with run held high.
    stepCycles(20);
    checkOutput("b_pre_reset_flags", flagsB(), 8'h81);
    #1 rst = 1'b1;
    #1;
    checkOutput("b_async_reset_flags", flagsB(), 8'h00);
    checkOutput("b_async_reset_xy", {b_if.o_x_pixel, b_if.o_y_pixel}, 0);
    checkOutput("a_async_reset_flags", flagsA(), 8'h60);
    @(posedge clk);
    #1;
    checkOutput("b_held_reset_flags", flagsB(), 8'h00);
    rst = 1'b0;
    stepCycles(1);
    checkOutput("b_after_reset_flags", flagsB(), 8'h97);
    checkOutput("b_after_reset_xy", {b_if.o_x_pixel, b_if.o_y_pixel}, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
